spi_cfg_regfile: RTL and testbench
==================================

// Module: spi_cfg_regfile
// PURPOSE
// Parametrised SPI configuration slave: framed (cs_n) mode-0 serial link with command byte, auto-incrementing
// address and burst read/write. Holds N_WREG digital config registers and drives byte-wide load strobes into
// N_AREG analog shift registers of AREG_BYTES bytes each. All registers read back over poci. Sits between pads and core.
// PARAMETERS
// DW          8      data/byte width (bits per transfer unit)
// AW          7      address width; command byte = {rw, addr[AW-1:0]}, rw=1 read
// N_WREG      3      digital config registers, addresses WREG_BASE..WREG_BASE+N_WREG-1
// WREG_BASE   1      first digital register address (address 0 = read-only ID)
// N_AREG      8      analog registers
// AREG_BYTES  7      bytes per analog register; region starts at AREG_BASE=WREG_BASE+N_WREG
// ID_VALUE    8'h51  value returned when reading address 0
// PORTS
// sclk           in   1               serial clock; sample on posedge, poci launched on negedge
// rstn           in   1               reset, asynchronous, active-low; clears everything
// cs_n           in   1               frame select, active-low; high = async frame abort (registers retained)
// pico           in   1               serial data in, MSB first
// poci           out  1               serial data out, MSB first
// poci_oe        out  1               poci driver enable
// wreg           out  N_WREG*DW       digital registers, reg i at [i*DW +: DW]
// wr_strobe      out  N_WREG          one-hot, one sclk cycle, register i just written
// areg_sel       out  N_AREG          one-hot analog register addressed by pointer
// areg_byte_sel  out  $clog2(AREG_BYTES) byte within analog reg; all-ones = none
// areg_wr        out  1               one-cycle write pulse qualifying areg_sel/byte_sel/areg_wdata
// areg_wdata     out  DW              byte written to analog reg
// areg_rdata     in   DW              readback of selected analog byte (combinational from areg_sel/byte_sel)
// frame_err      out  1               sticky: access to unmapped address
// BEHAVIOUR
// - Reset (rstn=0): wreg/wr_strobe/areg_sel/areg_wr/areg_wdata/poci/poci_oe/frame_err=0; areg_byte_sel=all ones; FSM=IDLE.
// - Frame reset frst_n = rstn & ~cs_n clears FSM, bit_cnt, shift regs, addr_ptr, poci_oe only. wreg, frame_err kept.
// - FSM: IDLE -(cs_n low)-> CMD; CMD -(DW bits)-> DATA; DATA loops per byte until cs_n high -> IDLE.
// - bit_cnt 0..DW-1, wraps at DW. Byte completes on posedge with bit_cnt==DW-1 using {rx_shift, pico}.
// - CMD complete: rw<=byte[DW-1], addr_ptr<=byte[AW-1:0]; frame_err cleared here (new frame), then re-evaluated.
// - DATA write complete: addr in wreg range -> wreg[idx]<=byte, wr_strobe[idx]=1 next cycle for one cycle.
//   In areg range -> areg_wdata<=byte, areg_wr=1 one cycle, with current areg_sel/byte_sel. Address 0 / unmapped:
//   write dropped, frame_err<=1. addr_ptr<=addr_ptr+1 (mod 2^AW, wraps to 0).
// - areg_sel/areg_byte_sel registered from next addr_ptr on the same edge it updates (aligned with pointer);
//   index=(addr-AREG_BASE)/AREG_BYTES, byte=(addr-AREG_BASE)%AREG_BYTES via constant LUT, no divider.
//   Outside areg region: areg_sel=0, byte_sel=all ones.
// - Read (rw=1): on negedge with bit_cnt==0 in DATA, tx_shift<=rdata(addr_ptr) (ID / wreg / areg_rdata / 0 unmapped
//   + frame_err); other negedges shift left. poci=tx_shift MSB; 0 when not reading. poci_oe=~cs_n & rw & DATA.
// - Latency: wreg visible 1 sclk after last bit; first read bit valid on negedge after CMD byte's last posedge.
// - cs_n high mid-byte: partial byte discarded, no strobe, pointer unchanged state lost; next frame needs new CMD.
// - Read frames never modify registers; burst continues indefinitely across wrap.
// STRUCTURE
// - Package spi_cfg_pkg: state_t {IDLE,CMD,DATA}; RW_BIT position; ID_VALUE default; region-classify function.
// - Sub-module spi_addr_decode: pure function of address -> region, wreg idx, areg one-hot, byte_sel (LUT generate).
// - Top: FSM, bit_cnt, rx/tx shift regs, addr_ptr, wreg array, strobe and error flops.
// TESTING
// - Reset: pulse rstn -> wreg=0, areg_byte_sel=3'b111, poci=0, poci_oe=0, frame_err=0.
// - Write burst: cmd 8'h01, data A5,3C,0F -> wreg={0F,3C,A5}; wr_strobe 001,010,100 one cycle each.
// - Read burst: cmd 8'h80, then 4 bytes -> poci returns 51,A5,3C,0F MSB first; poci_oe high only in DATA.
// - Analog: cmd 8'h0B data 77 -> areg_sel=8'h02, byte_sel=0, areg_wr pulse, areg_wdata=77; addr 59 -> sel 8'h80,
//   byte 6; addr 60 write -> no strobe, frame_err=1 until next CMD.
// - Abort: cmd 8'h02, 5 data bits then cs_n high -> wreg[1] unchanged; next frame cmd 8'h02 data 99 -> wreg[1]=99.
// - rstn low mid-burst read -> all outputs to reset values asynchronously; subsequent frame works.

Source files
------------

// File: rtl/spi_cfg_pkg.sv
// Shared types and helpers for the SPI configuration register file.
//   state_t  : serial frame FSM states
//   region_t : address map classification (ID / digital / analog / unmapped)
//   classify : maps an address to its region given the map parameters
package spi_cfg_pkg;

    typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

    typedef enum logic [1:0] {RG_ID, RG_WREG, RG_AREG, RG_NONE} region_t;

    // Read/write flag sits in the MSB of the command byte (default 8-bit link).
    localparam int          RW_BIT       = 7;
    localparam logic [7:0]  ID_VALUE_DEF = 8'h51;

    function automatic region_t classify(
        input int unsigned addr,
        input int unsigned wreg_base,
        input int unsigned n_wreg,
        input int unsigned areg_base,
        input int unsigned n_areg_addr
    );
        if (addr == 0)
            return RG_ID;
        else if (addr >= wreg_base && addr < wreg_base + n_wreg)
            return RG_WREG;
        else if (addr >= areg_base && addr < areg_base + n_areg_addr)
            return RG_AREG;
        else
            return RG_NONE;
    endfunction

endpackage

// File: rtl/spi_addr_decode.sv
// Pure combinational address decoder.
//   addr     in  : register address
//   region   out : region of addr
//   wreg_idx out : digital register index (meaningful in RG_WREG only)
//   areg_sel out : one-hot analog register (0 outside analog region)
//   byte_sel out : byte within analog register (all ones outside analog region)
// The analog split into register/byte is a constant table built at
// elaboration time, so no divider is synthesised.
module spi_addr_decode
    import spi_cfg_pkg::*;
#(
    parameter int AW         = 7,
    parameter int WREG_BASE  = 1,
    parameter int N_WREG     = 3,
    parameter int N_AREG     = 8,
    parameter int AREG_BYTES = 7,
    parameter int WIW        = 2,
    parameter int BSW        = 3
) (
    input  logic [AW-1:0]     addr,
    output region_t           region,
    output logic [WIW-1:0]    wreg_idx,
    output logic [N_AREG-1:0] areg_sel,
    output logic [BSW-1:0]    byte_sel
);

    localparam int AREG_BASE = WREG_BASE + N_WREG;
    localparam int N_AADDR   = N_AREG * AREG_BYTES;
    localparam int NADDR     = 1 << AW;

    logic [N_AREG-1:0] sel_lut  [NADDR];
    logic [BSW-1:0]    byte_lut [NADDR];

    for (genvar a = 0; a < NADDR; a++) begin : g_lut
        if (a >= AREG_BASE && a < AREG_BASE + N_AADDR) begin : g_in
            localparam int OFF = a - AREG_BASE;
            assign sel_lut[a]  = N_AREG'(1) << (OFF / AREG_BYTES);
            assign byte_lut[a] = BSW'(OFF % AREG_BYTES);
        end else begin : g_out
            assign sel_lut[a]  = '0;
            assign byte_lut[a] = '1;
        end
    end

    assign region   = classify(32'(addr), WREG_BASE, N_WREG, AREG_BASE, N_AADDR);
    assign areg_sel = sel_lut[addr];
    assign byte_sel = byte_lut[addr];

    always_comb begin
        wreg_idx = '0;
        for (int i = 0; i < N_WREG; i++)
            if (addr == AW'(WREG_BASE + i))
                wreg_idx = WIW'(i);
    end

endmodule

// File: rtl/spi_cfg_regfile.sv
// SPI mode-0 configuration slave with burst read/write and auto-increment.
//   sclk/rstn          : serial clock, async active-low reset
//   cs_n/pico/poci     : frame select, data in, data out (MSB first)
//   poci_oe            : poci driver enable (read frames, data phase)
//   wreg/wr_strobe     : digital config registers and per-register write pulse
//   areg_*             : analog shift-register byte write port and readback
//   frame_err          : sticky unmapped-access flag, cleared by next command
//
// state | meaning
// IDLE  | frame just opened, first command bit being captured
// CMD   | shifting in remaining command bits
// DATA  | byte-wise data transfer, pointer advances per byte
module spi_cfg_regfile
    import spi_cfg_pkg::*;
#(
    parameter int             DW         = 8,
    parameter int             AW         = 7,
    parameter int             N_WREG     = 3,
    parameter int             WREG_BASE  = 1,
    parameter int             N_AREG     = 8,
    parameter int             AREG_BYTES = 7,
    parameter logic [DW-1:0]  ID_VALUE   = DW'(ID_VALUE_DEF)
) (
    input  logic                          sclk,
    input  logic                          rstn,
    input  logic                          cs_n,
    input  logic                          pico,
    output logic                          poci,
    output logic                          poci_oe,
    output logic [N_WREG*DW-1:0]          wreg,
    output logic [N_WREG-1:0]             wr_strobe,
    output logic [N_AREG-1:0]             areg_sel,
    output logic [$clog2(AREG_BYTES)-1:0] areg_byte_sel,
    output logic                          areg_wr,
    output logic [DW-1:0]                 areg_wdata,
    input  logic [DW-1:0]                 areg_rdata,
    output logic                          frame_err
);

    localparam int CW  = $clog2(DW);
    localparam int BSW = $clog2(AREG_BYTES);
    localparam int WIW = (N_WREG > 1) ? $clog2(N_WREG) : 1;

    // Frame-scoped logic is held in reset whenever the frame is closed.
    logic frst_n;
    assign frst_n = rstn & ~cs_n;

    state_t            state;
    logic [CW-1:0]     bit_cnt;
    logic [DW-2:0]     rx_shift;
    logic [DW-1:0]     byte_in, tx_shift, rdata;
    logic [AW-1:0]     addr_ptr, ptr_nxt;
    logic              rw;
    region_t           region_q, dec_region;
    logic [WIW-1:0]    widx_q, dec_widx;
    logic [N_AREG-1:0] dec_sel;
    logic [BSW-1:0]    dec_byte;
    logic [DW-1:0]     wreg_q [N_WREG];
    logic              byte_done, cmd_done, data_done, areg_hold;

    assign byte_in   = {rx_shift, pico};
    assign byte_done = (bit_cnt == CW'(DW-1));
    assign cmd_done  = byte_done && (state != DATA);
    assign data_done = byte_done && (state == DATA);
    // Keep the analog select on the byte being written while areg_wr is high.
    assign areg_hold = data_done && !rw && (region_q == RG_AREG);

    always_comb begin
        ptr_nxt = addr_ptr;
        if (cmd_done)
            ptr_nxt = byte_in[AW-1:0];
        else if (data_done)
            ptr_nxt = addr_ptr + AW'(1);
    end

    // Decode the next pointer so region/select registers stay aligned with it.
    spi_addr_decode #(
        .AW(AW), .WREG_BASE(WREG_BASE), .N_WREG(N_WREG),
        .N_AREG(N_AREG), .AREG_BYTES(AREG_BYTES), .WIW(WIW), .BSW(BSW)
    ) u_dec (
        .addr     (ptr_nxt),
        .region   (dec_region),
        .wreg_idx (dec_widx),
        .areg_sel (dec_sel),
        .byte_sel (dec_byte)
    );

    always_comb begin
        rdata = '0;
        case (region_q)
            RG_ID:   rdata = ID_VALUE;
            RG_WREG: begin
                for (int i = 0; i < N_WREG; i++)
                    if (widx_q == WIW'(i))
                        rdata = wreg_q[i];
            end
            RG_AREG: rdata = areg_rdata;
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge sclk or negedge frst_n) begin
        if (!frst_n) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            rx_shift <= '0;
            addr_ptr <= '0;
            rw       <= 1'b0;
            region_q <= RG_ID;
            widx_q   <= '0;
        end else begin
            bit_cnt  <= byte_done ? '0 : bit_cnt + CW'(1);
            rx_shift <= byte_in[DW-2:0];
            addr_ptr <= ptr_nxt;
            region_q <= dec_region;
            widx_q   <= dec_widx;
            if (cmd_done)
                rw <= byte_in[DW-1];
            case (state)
                IDLE:    state <= CMD;
                CMD:     if (cmd_done) state <= DATA;
                DATA:    state <= DATA;
                default: state <= IDLE;
            endcase
        end
    end

    // Read data is loaded at the start of each byte and shifted out MSB first.
    always_ff @(negedge sclk or negedge frst_n) begin
        if (!frst_n)
            tx_shift <= '0;
        else if (state == DATA && rw)
            tx_shift <= (bit_cnt == '0) ? rdata : {tx_shift[DW-2:0], 1'b0};
    end

    assign poci_oe = ~cs_n & rw & (state == DATA);
    assign poci    = poci_oe & tx_shift[DW-1];

    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < N_WREG; i++)
                wreg_q[i] <= '0;
            wr_strobe     <= '0;
            areg_wr       <= 1'b0;
            areg_wdata    <= '0;
            areg_sel      <= '0;
            areg_byte_sel <= '1;
            frame_err     <= 1'b0;
        end else begin
            wr_strobe <= '0;
            areg_wr   <= 1'b0;
            if (!areg_hold) begin
                areg_sel      <= dec_sel;
                areg_byte_sel <= dec_byte;
            end
            if (cmd_done)
                frame_err <= 1'b0;
            if (data_done) begin
                if (!rw) begin
                    case (region_q)
                        RG_WREG: begin
                            for (int i = 0; i < N_WREG; i++)
                                if (widx_q == WIW'(i)) begin
                                    wreg_q[i]    <= byte_in;
                                    wr_strobe[i] <= 1'b1;
                                end
                        end
                        RG_AREG: begin
                            areg_wdata <= byte_in;
                            areg_wr    <= 1'b1;
                        end
                        default: frame_err <= 1'b1;
                    endcase
                end else if (region_q == RG_NONE) begin
                    frame_err <= 1'b1;
                end
            end
        end
    end

    for (genvar i = 0; i < N_WREG; i++) begin : g_wreg_out
        assign wreg[i*DW +: DW] = wreg_q[i];
    end

endmodule

// File: tb/tb_spi_cfg_regfile.sv
module tb_spi_cfg_regfile;

    logic        sclk = 1'b0;
    logic        rstn, cs_n, pico;
    logic        poci, poci_oe, areg_wr, frame_err;
    logic [23:0] wreg;
    logic [2:0]  wr_strobe, areg_byte_sel;
    logic [7:0]  areg_sel, areg_wdata, areg_rdata;

    always #5 sclk = ~sclk;

    spi_cfg_regfile dut (
        .sclk          (sclk),
        .rstn          (rstn),
        .cs_n          (cs_n),
        .pico          (pico),
        .poci          (poci),
        .poci_oe       (poci_oe),
        .wreg          (wreg),
        .wr_strobe     (wr_strobe),
        .areg_sel      (areg_sel),
        .areg_byte_sel (areg_byte_sel),
        .areg_wr       (areg_wr),
        .areg_wdata    (areg_wdata),
        .areg_rdata    (areg_rdata),
        .frame_err     (frame_err)
    );

    // Analog shift-register model: 8 registers x 7 bytes.
    logic [7:0] amem [56];
    initial for (int i = 0; i < 56; i++) amem[i] = 8'h00;

    always_comb begin
        areg_rdata = 8'h00;
        for (int i = 0; i < 8; i++)
            if (areg_sel[i] && areg_byte_sel < 3'd7)
                areg_rdata = amem[i*7 + int'(areg_byte_sel)];
    end

    always @(posedge sclk)
        if (areg_wr)
            for (int i = 0; i < 8; i++)
                if (areg_sel[i] && areg_byte_sel < 3'd7)
                    amem[i*7 + int'(areg_byte_sel)] <= areg_wdata;

    int total = 0;
    int bad   = 0;

    logic [31:0] wq [$];
    logic [7:0]  rq [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] ev_strobe(input logic [2:0] s, input logic [23:0] w);
        return {4'h1, 1'b0, s, w};
    endfunction

    function automatic logic [31:0] ev_areg(input logic [7:0] sel, input logic [2:0] b,
                                            input logic [7:0] d);
        return {4'h2, 9'h000, sel, b, d};
    endfunction

    // Write-side monitor: any strobe/areg_wr pulse is matched to the next expectation.
    logic [31:0] w_got;
    always @(negedge sclk) begin
        if (rstn && (wr_strobe != 3'b000 || areg_wr)) begin
            w_got = (wr_strobe != 3'b000) ? ev_strobe(wr_strobe, wreg)
                                          : ev_areg(areg_sel, areg_byte_sel, areg_wdata);
            if (wq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got %h want none", w_got);
            end else begin
                chk("write_event", w_got, wq.pop_front());
            end
        end
    end

    // Read-side monitor: host samples poci on posedge, assembles bytes.
    int         rcnt = 0;
    logic [7:0] rbyte = 8'h00;
    always @(posedge sclk) begin
        if (!rstn || cs_n) begin
            rcnt = 0;
        end else if (poci_oe) begin
            rbyte = {rbyte[6:0], poci};
            rcnt++;
            if (rcnt == 8) begin
                rcnt = 0;
                if (rq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_read: got %h want none", rbyte);
                end else begin
                    chk("read_byte", {24'h0, rbyte}, {24'h0, rq.pop_front()});
                end
            end
        end
    end

    task automatic send_bits(input logic [7:0] b, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) begin
            pico = b[i];
            @(negedge sclk);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits(b, 7, 0);
    endtask

    task automatic start_frame();
        @(negedge sclk);
        cs_n = 1'b0;
    endtask

    task automatic end_frame();
        cs_n = 1'b1;
        pico = 1'b0;
        repeat (2) @(negedge sclk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        rstn = 1'b0;
        cs_n = 1'b1;
        pico = 1'b0;
        #23 rstn = 1'b1;
        @(negedge sclk);

        chk("rst_wreg",      wreg,          32'h0);
        chk("rst_strobe",    wr_strobe,     32'h0);
        chk("rst_areg_sel",  areg_sel,      32'h0);
        chk("rst_byte_sel",  areg_byte_sel, 32'h7);
        chk("rst_areg_wr",   areg_wr,       32'h0);
        chk("rst_poci",      poci,          32'h0);
        chk("rst_poci_oe",   poci_oe,       32'h0);
        chk("rst_frame_err", frame_err,     32'h0);

        // Write burst to digital registers 1..3
        wq.push_back(ev_strobe(3'b001, 24'h0000A5));
        wq.push_back(ev_strobe(3'b010, 24'h003CA5));
        wq.push_back(ev_strobe(3'b100, 24'h0F3CA5));
        start_frame();
        send_byte(8'h01);
        send_byte(8'hA5);
        send_byte(8'h3C);
        send_byte(8'h0F);
        end_frame();
        chk("wreg_after_burst", wreg, 32'h000F3CA5);

        // Read burst from address 0
        rq.push_back(8'h51);
        rq.push_back(8'hA5);
        rq.push_back(8'h3C);
        rq.push_back(8'h0F);
        start_frame();
        send_bits(8'h80, 7, 4);
        chk("oe_in_cmd", poci_oe, 32'h0);
        send_bits(8'h80, 3, 0);
        chk("oe_in_data", poci_oe, 32'h1);
        repeat (4) send_byte(8'h00);
        end_frame();
        chk("oe_after_frame", poci_oe, 32'h0);
        chk("err_after_read", frame_err, 32'h0);

        // Analog write at address 11 -> register 1, byte 0
        wq.push_back(ev_areg(8'h02, 3'd0, 8'h77));
        start_frame();
        send_byte(8'h0B);
        chk("sel_addr11",  areg_sel,      32'h02);
        chk("byte_addr11", areg_byte_sel, 32'h0);
        send_byte(8'h77);
        end_frame();

        // Last analog byte (59), then unmapped 60
        wq.push_back(ev_areg(8'h80, 3'd6, 8'h11));
        start_frame();
        send_byte(8'h3B);
        chk("sel_addr59",  areg_sel,      32'h80);
        chk("byte_addr59", areg_byte_sel, 32'h6);
        send_byte(8'h11);
        chk("err_before_60", frame_err, 32'h0);
        send_byte(8'h22);
        chk("err_at_60", frame_err, 32'h1);
        end_frame();
        chk("err_sticky", frame_err, 32'h1);

        // Read back analog byte written earlier; new command clears frame_err
        rq.push_back(8'h77);
        start_frame();
        send_byte(8'h8B);
        chk("err_cleared_by_cmd", frame_err, 32'h0);
        send_byte(8'h00);
        end_frame();

        // Abort mid-byte: no strobe, register unchanged
        start_frame();
        send_byte(8'h02);
        send_bits(8'hFF, 7, 3);
        end_frame();
        chk("abort_wreg1", {24'h0, wreg[15:8]}, 32'h3C);

        wq.push_back(ev_strobe(3'b010, 24'h0F99A5));
        start_frame();
        send_byte(8'h02);
        send_byte(8'h99);
        end_frame();
        chk("wreg_after_abort", wreg, 32'h000F99A5);

        // Unmapped read, then async reset mid-burst
        rq.push_back(8'h00);
        start_frame();
        send_byte(8'hBC);
        send_byte(8'h00);
        chk("err_unmapped_read", frame_err, 32'h1);
        send_bits(8'h00, 7, 5);
        #2 rstn = 1'b0;
        #1;
        chk("arst_wreg",      wreg,          32'h0);
        chk("arst_poci",      poci,          32'h0);
        chk("arst_poci_oe",   poci_oe,       32'h0);
        chk("arst_frame_err", frame_err,     32'h0);
        chk("arst_byte_sel",  areg_byte_sel, 32'h7);
        chk("arst_areg_sel",  areg_sel,      32'h0);
        @(negedge sclk);
        cs_n = 1'b1;
        rstn = 1'b1;
        repeat (2) @(negedge sclk);

        // Frames work after reset
        wq.push_back(ev_strobe(3'b100, 24'h5A0000));
        start_frame();
        send_byte(8'h03);
        send_byte(8'h5A);
        end_frame();

        rq.push_back(8'h5A);
        rq.push_back(8'h00);
        start_frame();
        send_byte(8'h83);
        send_byte(8'h00);
        send_byte(8'h00);
        end_frame();

        repeat (4) @(negedge sclk);
        chk("write_events_left", wq.size(), 32'h0);
        chk("read_bytes_left",   rq.size(), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
